mem_responder: RTL and testbench
================================

// Module: mem_responder
// PURPOSE
// - Responder end of the core's imem/dmem request/response interface: serves the fetch port and the data port from one
//   internal single-port word array with a programmable fixed latency.
// - Sits opposite the pipelined core in simulation and FPGA-bringup tops; stands in for the cache/memory hierarchy.
// - Arbitrates the two ports onto one array: one transaction in flight, round-robin between ports.
// PARAMETERS
// - DEPTH_WORDS  1024        : number of 32-bit words in the array; power of two, >= 4.
// - LATENCY      2           : cycles from accept edge to resp cycle; legal range 1..15.
// - BASE_ADDR    32'h6000_0000 : byte address that maps to word 0.
// PORTS
// - clk         in   1   : single clock, all state on rising edge.
// - rst         in   1   : asynchronous, active-low reset.
// - imem_addr   in   32  : fetch byte address; held stable by the core until imem_resp.
// - imem_rmask  in   4   : fetch byte read mask; nonzero = request pending.
// - imem_rdata  out  32  : fetch read data, valid only while imem_resp=1.
// - imem_resp   out  1   : one-cycle completion pulse for the fetch port.
// - dmem_addr   in   32  : data byte address; held stable until dmem_resp.
// - dmem_rmask  in   4   : data byte read mask.
// - dmem_wmask  in   4   : data byte write mask; rmask|wmask nonzero = request pending.
// - dmem_wdata  in   32  : store data, byte lanes selected by dmem_wmask.
// - dmem_rdata  out  32  : data read data, valid only while dmem_resp=1.
// - dmem_resp   out  1   : one-cycle completion pulse for the data port.
// BEHAVIOUR
// - Reset (rst=0, async): state IDLE, latency counter 0, last_grant=IMEM; imem_resp=0, dmem_resp=0,
//   imem_rdata=0, dmem_rdata=0. Array contents not reset; retained across reset.
// - FSM: IDLE -> BUSY -> RESP -> IDLE.
//   IDLE: if any port pending, capture grant, addr, masks, wdata at the edge; load counter=LATENCY-1;
//         go BUSY (or RESP directly when LATENCY=1).
//   BUSY: decrement counter each cycle; counter==1 -> RESP next cycle.
//   RESP: assert granted port's resp for exactly one cycle; perform array access; -> IDLE.
// - Latency: request visible in cycle T while IDLE -> resp high in cycle T+LATENCY. The cycle after RESP is
//   always IDLE, so the request still held during the resp cycle is never re-accepted; back-to-back minimum
//   period per port is LATENCY+1 cycles.
// - Arbitration: both pending in IDLE -> port opposite last_grant wins; last_grant updated on accept.
//   Single pending port wins immediately. Losing port waits; its inputs are not sampled.
// - Address map: word index = (addr - BASE_ADDR) >> 2, mod 2^32; addr[1:0] ignored (masks are byte-lane
//   aligned by the core). Index >= DEPTH_WORDS = out of range: rdata=0, write dropped, resp still given.
// - Read: rdata = full 32-bit array word (all lanes), regardless of rmask; core does lane extraction.
// - Write: at the RESP edge, lanes with wmask[i]=1 take wdata[8i+7:8i]; other lanes unchanged.
// - rmask and wmask both nonzero: rdata returns pre-write word; write commits same edge.
// - Request masks dropping to zero after accept: ignored; transaction completes and resp still pulses.
// - Reset mid-transaction: transaction abandoned, no resp, no write committed.
// - Outputs registered: resp and rdata driven from flops, no combinational input-to-output path.
// CONFIGURATION
// - MEM_RESP_ERR_EN defined: adds outputs imem_err and dmem_err (1 bit each, reset 0), asserted with the
//   corresponding resp for exactly that cycle when the captured address is out of range; 0 otherwise.
// - MEM_RESP_ERR_EN undefined: err ports absent; out-of-range behaviour is otherwise identical.
// TESTING
// - LATENCY=2, IDLE, dmem write addr=BASE+0x10 wmask=4'b1111 wdata=32'hDEADBEEF at T -> dmem_resp only at T+2;
//   then read same addr -> dmem_rdata=32'hDEADBEEF with resp.
// - Byte write wmask=4'b0100 wdata=32'h00AA0000 over 32'hDEADBEEF -> subsequent read returns 32'hDEAABEEF.
// - imem and dmem requests first visible same cycle after reset -> dmem served first (last_grant=IMEM),
//   imem_resp follows at T+LATENCY+1+LATENCY; repeat both pending -> grant alternates.
// - Read addr=BASE+4*DEPTH_WORDS -> resp at T+LATENCY, rdata=0, no array change; with MEM_RESP_ERR_EN, dmem_err=1.
// - Assert rst=0 one cycle before expected resp -> no resp pulse, targeted word unchanged, next request normal.
// - LATENCY=1, imem_rmask held 4'hF continuously at stepping addresses -> one resp every 2 cycles, correct data.

Source files
------------

// File: rtl/mem_responder_if.sv
// Request/response bundle between the core (master) and the memory responder (slave).
// MEM_RESP_ERR_EN adds the per-port out-of-range error flags.
interface mem_responder_if;
    logic [31:0] imem_addr;
    logic [3:0]  imem_rmask;
    logic [31:0] imem_rdata;
    logic        imem_resp;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_rmask;
    logic [3:0]  dmem_wmask;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_resp;
`ifdef MEM_RESP_ERR_EN
    logic        imem_err;
    logic        dmem_err;
`endif

    modport master (
        output imem_addr, imem_rmask,
        input  imem_rdata, imem_resp,
        output dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata,
        input  dmem_rdata, dmem_resp
`ifdef MEM_RESP_ERR_EN
        , input imem_err, dmem_err
`endif
    );

    modport slave (
        input  imem_addr, imem_rmask,
        output imem_rdata, imem_resp,
        input  dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata,
        output dmem_rdata, dmem_resp
`ifdef MEM_RESP_ERR_EN
        , output imem_err, dmem_err
`endif
    );
endinterface

// File: rtl/mem_responder.sv
// Serves the imem and dmem ports from one word array, one transaction at a time, fixed latency, round-robin.
// Define MEM_RESP_ERR_EN to add imem_err/dmem_err flags pulsed with resp on out-of-range addresses.
module mem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h6000_0000
) (
    input  logic            clk,
    input  logic            rst,
    mem_responder_if.slave  bus
);
    localparam int unsigned AW       = $clog2(DEPTH_WORDS);
    localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);
    localparam logic        GRANT_IMEM = 1'b0;
    localparam logic        GRANT_DMEM = 1'b1;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    function automatic logic [31:0] word_idx(input logic [31:0] addr);
        return (addr - BASE_ADDR) >> 2;
    endfunction

    logic [31:0] mem_q [0:DEPTH_WORDS-1];

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        last_grant_q, last_grant_d;
    logic        grant_q, grant_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  wmask_q, wmask_d;
    logic [31:0] wdata_q, wdata_d;
    logic        imem_resp_q, imem_resp_d;
    logic        dmem_resp_q, dmem_resp_d;
    logic [31:0] imem_rdata_q, imem_rdata_d;
    logic [31:0] dmem_rdata_q, dmem_rdata_d;
`ifdef MEM_RESP_ERR_EN
    logic        imem_err_q, imem_err_d;
    logic        dmem_err_q, dmem_err_d;
`endif

    logic        imem_pend, dmem_pend, go_resp;
    logic [31:0] rd_idx, rd_word;
    logic        rd_hit;
    logic [31:0] wr_idx, wr_word_d;
    logic        wr_en;

    assign imem_pend = |bus.imem_rmask;
    assign dmem_pend = (|bus.dmem_rmask) || (|bus.dmem_wmask);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        addr_d       = addr_q;
        wmask_d      = wmask_q;
        wdata_d      = wdata_q;
        go_resp      = 1'b0;
        case (state_q)
            IDLE: begin
                if (imem_pend || dmem_pend) begin
                    // With both pending, the port not served last time wins.
                    grant_d      = dmem_pend && (!imem_pend || last_grant_q == GRANT_IMEM);
                    last_grant_d = grant_d;
                    addr_d       = grant_d ? bus.dmem_addr  : bus.imem_addr;
                    wmask_d      = grant_d ? bus.dmem_wmask : 4'b0000;
                    wdata_d      = bus.dmem_wdata;
                    cnt_d        = CNT_INIT;
                    if (LATENCY == 1) go_resp = 1'b1;
                    else              state_d = BUSY;
                end
            end
            BUSY: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) go_resp = 1'b1;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (go_resp) state_d = RESP;

        // Read data is captured on entry to RESP, so a read+write returns the pre-write word.
        rd_idx       = word_idx(addr_d);
        rd_hit       = rd_idx < 32'(DEPTH_WORDS);
        rd_word      = rd_hit ? mem_q[rd_idx[AW-1:0]] : 32'h0;
        imem_resp_d  = go_resp && (grant_d == GRANT_IMEM);
        dmem_resp_d  = go_resp && (grant_d == GRANT_DMEM);
        imem_rdata_d = imem_resp_d ? rd_word : 32'h0;
        dmem_rdata_d = dmem_resp_d ? rd_word : 32'h0;
`ifdef MEM_RESP_ERR_EN
        imem_err_d   = imem_resp_d && !rd_hit;
        dmem_err_d   = dmem_resp_d && !rd_hit;
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            last_grant_q <= GRANT_IMEM;
            grant_q      <= GRANT_IMEM;
            addr_q       <= 32'h0;
            wmask_q      <= 4'b0000;
            wdata_q      <= 32'h0;
            imem_resp_q  <= 1'b0;
            dmem_resp_q  <= 1'b0;
            imem_rdata_q <= 32'h0;
            dmem_rdata_q <= 32'h0;
`ifdef MEM_RESP_ERR_EN
            imem_err_q   <= 1'b0;
            dmem_err_q   <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            addr_q       <= addr_d;
            wmask_q      <= wmask_d;
            wdata_q      <= wdata_d;
            imem_resp_q  <= imem_resp_d;
            dmem_resp_q  <= dmem_resp_d;
            imem_rdata_q <= imem_rdata_d;
            dmem_rdata_q <= dmem_rdata_d;
`ifdef MEM_RESP_ERR_EN
            imem_err_q   <= imem_err_d;
            dmem_err_q   <= dmem_err_d;
`endif
        end
    end

    // Store commits on the edge leaving RESP; a reset held at that edge drops it.
    always_comb begin
        wr_idx    = word_idx(addr_q);
        wr_en     = rst && (state_q == RESP) && (grant_q == GRANT_DMEM) && (|wmask_q)
                    && (wr_idx < 32'(DEPTH_WORDS));
        wr_word_d = mem_q[wr_idx[AW-1:0]];
        for (int i = 0; i < 4; i++) begin
            if (wmask_q[i]) wr_word_d[8*i +: 8] = wdata_q[8*i +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_idx[AW-1:0]] <= wr_word_d;
    end

    assign bus.imem_resp  = imem_resp_q;
    assign bus.dmem_resp  = dmem_resp_q;
    assign bus.imem_rdata = imem_rdata_q;
    assign bus.dmem_rdata = dmem_rdata_q;
`ifdef MEM_RESP_ERR_EN
    assign bus.imem_err   = imem_err_q;
    assign bus.dmem_err   = dmem_err_q;
`endif
endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: latency, byte writes, arbitration, out-of-range, reset abort, LATENCY=1 streaming.
module tb_mem_responder;
    localparam logic [31:0] BASE = 32'h6000_0000;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
`ifdef MEM_RESP_ERR_EN
    logic last_err;
`endif

    always #5 clk = ~clk;

    mem_responder_if bus0 ();
    mem_responder_if bus1 ();

    mem_responder #(.DEPTH_WORDS(1024), .LATENCY(2), .BASE_ADDR(BASE)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    mem_responder #(.DEPTH_WORDS(1024), .LATENCY(1), .BASE_ADDR(BASE)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    task automatic idle_inputs();
        bus0.imem_addr = '0; bus0.imem_rmask = '0;
        bus0.dmem_addr = '0; bus0.dmem_rmask = '0; bus0.dmem_wmask = '0; bus0.dmem_wdata = '0;
        bus1.imem_addr = '0; bus1.imem_rmask = '0;
        bus1.dmem_addr = '0; bus1.dmem_rmask = '0; bus1.dmem_wmask = '0; bus1.dmem_wdata = '0;
    endtask

    // Issues one dmem request on bus0; lat is the cycle offset of the resp pulse (-1 if none within budget).
    task automatic dmem_txn(input logic [31:0] addr, input logic [3:0] rmask, input logic [3:0] wmask,
                            input logic [31:0] wdata, output int lat, output logic [31:0] rdata);
        @(posedge clk); #1;
        bus0.dmem_addr = addr; bus0.dmem_rmask = rmask; bus0.dmem_wmask = wmask; bus0.dmem_wdata = wdata;
        lat = -1; rdata = '0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (bus0.dmem_resp === 1'b1) begin
                lat = k; rdata = bus0.dmem_rdata;
`ifdef MEM_RESP_ERR_EN
                last_err = bus0.dmem_err;
`endif
                break;
            end
        end
        bus0.dmem_rmask = '0; bus0.dmem_wmask = '0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus0.imem_resp !== 1'b0) begin errors++; $display("FAIL rst_imem_resp: got %b expected 0", bus0.imem_resp); end
        checks++; if (bus0.dmem_resp !== 1'b0) begin errors++; $display("FAIL rst_dmem_resp: got %b expected 0", bus0.dmem_resp); end
        checks++; if (bus0.imem_rdata !== 32'h0) begin errors++; $display("FAIL rst_imem_rdata: got %h expected 0", bus0.imem_rdata); end
        checks++; if (bus0.dmem_rdata !== 32'h0) begin errors++; $display("FAIL rst_dmem_rdata: got %h expected 0", bus0.dmem_rdata); end
`ifdef MEM_RESP_ERR_EN
        checks++; if (bus0.dmem_err !== 1'b0) begin errors++; $display("FAIL rst_dmem_err: got %b expected 0", bus0.dmem_err); end
`endif
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_write_read();
        int lat; logic [31:0] rd;
        dmem_txn(BASE + 32'h10, 4'b0000, 4'b1111, 32'hDEADBEEF, lat, rd);
        checks++; if (lat !== 2) begin errors++; $display("FAIL wr_latency: got %0d expected 2", lat); end
        dmem_txn(BASE + 32'h10, 4'b1111, 4'b0000, 32'h0, lat, rd);
        checks++; if (lat !== 2) begin errors++; $display("FAIL rd_latency: got %0d expected 2", lat); end
        checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data: got %h expected deadbeef", rd); end
    endtask

    task automatic test_byte_write();
        int lat; logic [31:0] rd;
        dmem_txn(BASE + 32'h10, 4'b0000, 4'b0100, 32'h00AA0000, lat, rd);
        dmem_txn(BASE + 32'h10, 4'b1111, 4'b0000, 32'h0, lat, rd);
        checks++; if (rd !== 32'hDEAABEEF) begin errors++; $display("FAIL byte_write: got %h expected deaabeef", rd); end
        // Read and write together: returns the old word, write lands the same edge.
        dmem_txn(BASE + 32'h10, 4'b1111, 4'b0001, 32'h00000011, lat, rd);
        checks++; if (rd !== 32'hDEAABEEF) begin errors++; $display("FAIL rw_prewrite: got %h expected deaabeef", rd); end
        dmem_txn(BASE + 32'h10, 4'b1111, 4'b0000, 32'h0, lat, rd);
        checks++; if (rd !== 32'hDEAABE11) begin errors++; $display("FAIL rw_commit: got %h expected deaabe11", rd); end
    endtask

    task automatic test_arbitration();
        int d_t[2]; int i_t[2]; int nd; int ni; logic [31:0] i_data;
        nd = 0; ni = 0; i_data = '0; d_t[0] = -1; d_t[1] = -1; i_t[0] = -1; i_t[1] = -1;
        rst = 1'b0;
        @(posedge clk); @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        bus0.imem_addr = BASE + 32'h10; bus0.imem_rmask = 4'hF;
        bus0.dmem_addr = BASE + 32'h14; bus0.dmem_rmask = 4'hF;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (bus0.dmem_resp === 1'b1) begin if (nd < 2) d_t[nd] = k; nd++; end
            if (bus0.imem_resp === 1'b1) begin if (ni == 0) i_data = bus0.imem_rdata; if (ni < 2) i_t[ni] = k; ni++; end
            if (k == 11) begin bus0.imem_rmask = '0; bus0.dmem_rmask = '0; end
        end
        checks++; if (d_t[0] !== 2) begin errors++; $display("FAIL arb_dmem_first: got %0d expected 2", d_t[0]); end
        checks++; if (i_t[0] !== 5) begin errors++; $display("FAIL arb_imem_first: got %0d expected 5", i_t[0]); end
        checks++; if (d_t[1] !== 8) begin errors++; $display("FAIL arb_dmem_second: got %0d expected 8", d_t[1]); end
        checks++; if (i_t[1] !== 11) begin errors++; $display("FAIL arb_imem_second: got %0d expected 11", i_t[1]); end
        checks++; if (nd !== 2 || ni !== 2) begin errors++; $display("FAIL arb_resp_count: got d=%0d i=%0d expected 2 2", nd, ni); end
        checks++; if (i_data !== 32'hDEAABE11) begin errors++; $display("FAIL arb_imem_data: got %h expected deaabe11", i_data); end
    endtask

    task automatic test_out_of_range();
        int lat; logic [31:0] rd;
        dmem_txn(BASE, 4'b0000, 4'b1111, 32'h12345678, lat, rd);
        dmem_txn(BASE + 32'h1000, 4'b0000, 4'b1111, 32'hFFFFFFFF, lat, rd);
        checks++; if (lat !== 2) begin errors++; $display("FAIL oor_wr_latency: got %0d expected 2", lat); end
        dmem_txn(BASE + 32'h1000, 4'b1111, 4'b0000, 32'h0, lat, rd);
        checks++; if (lat !== 2) begin errors++; $display("FAIL oor_rd_latency: got %0d expected 2", lat); end
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL oor_rd_data: got %h expected 0", rd); end
`ifdef MEM_RESP_ERR_EN
        checks++; if (last_err !== 1'b1) begin errors++; $display("FAIL oor_err: got %b expected 1", last_err); end
`endif
        dmem_txn(BASE, 4'b1111, 4'b0000, 32'h0, lat, rd);
        checks++; if (rd !== 32'h12345678) begin errors++; $display("FAIL oor_no_alias: got %h expected 12345678", rd); end
`ifdef MEM_RESP_ERR_EN
        checks++; if (last_err !== 1'b0) begin errors++; $display("FAIL inrange_err: got %b expected 0", last_err); end
`endif
        dmem_txn(BASE - 32'h4, 4'b1111, 4'b0000, 32'h0, lat, rd);
        checks++; if (lat !== 2 || rd !== 32'h0) begin errors++; $display("FAIL below_base: got lat=%0d data=%h expected 2 0", lat, rd); end
    endtask

    task automatic test_reset_mid();
        int lat; logic [31:0] rd; int nresp;
        nresp = 0;
        dmem_txn(BASE + 32'h20, 4'b0000, 4'b1111, 32'hCAFEF00D, lat, rd);
        @(posedge clk); #1;
        bus0.dmem_addr = BASE + 32'h20; bus0.dmem_wmask = 4'hF; bus0.dmem_wdata = 32'h0BADBEEF;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (bus0.dmem_resp !== 1'b0) nresp++;
        end
        bus0.dmem_wmask = '0;
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (bus0.dmem_resp !== 1'b0) nresp++;
        end
        checks++; if (nresp !== 0) begin errors++; $display("FAIL abort_no_resp: got %0d pulses expected 0", nresp); end
        dmem_txn(BASE + 32'h20, 4'b1111, 4'b0000, 32'h0, lat, rd);
        checks++; if (lat !== 2) begin errors++; $display("FAIL abort_next_latency: got %0d expected 2", lat); end
        checks++; if (rd !== 32'hCAFEF00D) begin errors++; $display("FAIL abort_no_write: got %h expected cafef00d", rd); end
    endtask

    task automatic test_latency1_stream();
        logic [31:0] words [4];
        int lat; int n;
        words[0] = 32'hA0A00000; words[1] = 32'hB1B11111; words[2] = 32'hC2C22222; words[3] = 32'hD3D33333;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            bus1.dmem_addr = BASE + 32'(4 * i); bus1.dmem_wmask = 4'hF; bus1.dmem_wdata = words[i];
            lat = -1;
            for (int k = 0; k < 10; k++) begin
                @(negedge clk);
                if (bus1.dmem_resp === 1'b1) begin lat = k; break; end
            end
            bus1.dmem_wmask = '0;
            checks++; if (lat !== 1) begin errors++; $display("FAIL l1_wr_latency: got %0d expected 1", lat); end
        end
        n = 0;
        @(posedge clk); #1;
        bus1.imem_addr = BASE; bus1.imem_rmask = 4'hF;
        for (int k = 0; k < 20 && n < 4; k++) begin
            @(negedge clk);
            if (bus1.imem_resp === 1'b1) begin
                checks++; if (k !== 2 * n + 1) begin errors++; $display("FAIL l1_stream_time: got %0d expected %0d", k, 2 * n + 1); end
                checks++; if (bus1.imem_rdata !== words[n]) begin errors++; $display("FAIL l1_stream_data: got %h expected %h", bus1.imem_rdata, words[n]); end
                n++;
                bus1.imem_addr = BASE + 32'(4 * n);
            end
        end
        bus1.imem_rmask = '0;
        checks++; if (n !== 4) begin errors++; $display("FAIL l1_stream_count: got %0d expected 4", n); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_byte_write();
        test_arbitration();
        test_out_of_range();
        test_reset_mid();
        test_latency1_stream();
        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
